// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Streams a contiguous, wrapping window of register-file entries out over a
//   valid/ready interface for debug and trace dumps. The controller drives
//   the register file's read select from its index register. On the FETCH
//   cycle it captures the combinational read data into out_data. The
//   captured beat is then held stable while the downstream stalls.
//
//   Optional feature (macro REGDUMP_CHECKSUM_EN): after the last data beat
//   an extra beat carries the XOR of every word sent, flagged by out_csum.
//   Without the macro there is no checksum state and out_csum is tied low.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   start      one-cycle dump request, honoured only when idle
//   first_sel  first register index of the window (latched on start)
//   last_sel   last register index of the window (latched on start)
//   read_sel   read select to the register file
//   read_data  combinational read data from the register file
//   out_valid  out_data/out_index/out_csum hold a beat
//   out_ready  downstream accepts the beat
//   out_data   captured register word, or the checksum
//   out_index  register index of the current beat
//   out_csum   current beat is the checksum beat
//   busy       a dump is in progress
//   done       one-cycle pulse when a dump completes
module regfile_dump_reader #(
  parameter int data_width   = 32,
  parameter int select_width = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [select_width-1:0] first_sel,
  input  logic [select_width-1:0] last_sel,
  output logic [select_width-1:0] read_sel,
  input  logic [data_width-1:0]   read_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_width-1:0]   out_data,
  output logic [select_width-1:0] out_index,
  output logic                    out_csum,
  output logic                    busy,
  output logic                    done
);

  localparam logic [select_width-1:0] SEL_ONE = select_width'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    FIN
`ifdef REGDUMP_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [select_width-1:0] idx;
  logic [select_width-1:0] end_sel;
  logic                    handshake;

`ifdef REGDUMP_CHECKSUM_EN
  logic [data_width-1:0]   acc;
  logic                    csum_q;
`endif

  assign handshake = out_valid & out_ready;
  assign read_sel  = idx;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

`ifdef REGDUMP_CHECKSUM_EN
  assign out_csum = csum_q;
`else
  assign out_csum = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = FETCH;
      FETCH: next_state = SEND;
      SEND: begin
        if (handshake) begin
          if (idx == end_sel) begin
`ifdef REGDUMP_CHECKSUM_EN
            next_state = CSUM;
`else
            next_state = FIN;
`endif
          end else begin
            next_state = FETCH;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      // CSUM first loads the checksum beat, then waits for it to be taken
      CSUM:  if (handshake) next_state = FIN;
`endif
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Window index, captured beat and checksum accumulator. The beat is
  // captured in FETCH, so register-file writes during a SEND stall cannot
  // disturb out_data. idx wraps naturally at 2**select_width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      end_sel   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      acc       <= '0;
      csum_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= first_sel;
            end_sel <= last_sel;
`ifdef REGDUMP_CHECKSUM_EN
            acc     <= '0;
`endif
          end
        end
        FETCH: begin
          out_data  <= read_data;
          out_index <= idx;
          out_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          csum_q    <= 1'b0;
          acc       <= acc ^ read_data;
`endif
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            if (idx != end_sel) idx <= idx + SEL_ONE;
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        CSUM: begin
          if (!out_valid) begin
            out_data  <= acc;
            out_index <= end_sel;
            csum_q    <= 1'b1;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            csum_q    <= 1'b0;
            out_valid <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
